// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronized rx, oversampled with 3-sample majority per bit,
// stop-bit check, and a one-entry output register with so/ro handshake.
module uart_rx_core #(
    parameter int unsigned SYS_CLK_FREQ = 200_000_000,
    parameter int unsigned BAUD_RATE    = 19200,
    parameter int unsigned FRAME_WIDTH  = 8,
    parameter int unsigned OVERSAMPLE   = 16
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic [0:FRAME_WIDTH-1] dout,
    output logic                   so,
    input  logic                   ro,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);

    localparam int unsigned DIV   = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W   = $clog2(OVERSAMPLE);
    localparam int unsigned MID   = OVERSAMPLE / 2;
    localparam int unsigned BC_W  = $clog2(FRAME_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta, rx_sync, rx_prev;
    logic [DIV_W-1:0]       div_cnt;
    logic [S_W-1:0]         s_cnt;
    logic [1:0]             smp;
    logic [BC_W-1:0]        bit_cnt;
    logic [FRAME_WIDTH-1:0] shift_reg;
    logic                   deliver;

    logic fell, tick, decide, bit_end, bit_val;
    logic start_frame, shift_en, stop_ok, stop_bad;

    assign fell    = rx_prev & ~rx_sync;
    assign tick    = (div_cnt == DIV_W'(DIV - 1));
    assign decide  = tick && (s_cnt == S_W'(MID + 1));
    assign bit_end = tick && (s_cnt == S_W'(OVERSAMPLE - 1));
    // Third vote is the live sample taken on the decision tick itself.
    assign bit_val = (smp[0] & smp[1]) | (smp[0] & rx_sync) | (smp[1] & rx_sync);
    assign busy    = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fell) begin
                    state_d     = StStart;
                    start_frame = 1'b1;
                end
            end
            StStart: begin
                if (decide && bit_val) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                shift_en = decide;
                if (bit_end && (bit_cnt == BC_W'(FRAME_WIDTH))) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (decide) begin
                    state_d  = StIdle;
                    stop_ok  = bit_val;
                    stop_bad = ~bit_val;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            div_cnt   <= '0;
            s_cnt     <= '0;
            smp       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            deliver   <= 1'b0;
            dout      <= '0;
            so        <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            // Divider restarts on the start edge so ticks are phase-aligned to the frame.
            if (start_frame || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (start_frame) begin
                s_cnt <= '0;
            end else if (tick && busy) begin
                s_cnt <= (s_cnt == S_W'(OVERSAMPLE - 1)) ? '0 : s_cnt + 1'b1;
            end

            if (tick && (s_cnt == S_W'(MID - 1))) smp[0] <= rx_sync;
            if (tick && (s_cnt == S_W'(MID)))     smp[1] <= rx_sync;

            if (start_frame) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // LSB arrives first, so after FRAME_WIDTH shifts it sits in bit 0.
            if (shift_en) shift_reg <= {bit_val, shift_reg[FRAME_WIDTH-1:1]};

            deliver   <= stop_ok;
            frame_err <= stop_bad;
            overrun   <= deliver && so && !ro;

            if (deliver && (!so || ro)) begin
                so   <= 1'b1;
                dout <= shift_reg;
            end else if (so && ro) begin
                so <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: a bit-banged transmitter pushes expected bytes,
// a negedge monitor pops and compares on every so && ro transfer.
module tb_uart_rx_core;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned W        = 8;
    localparam int unsigned OS       = 8;
    localparam int          BIT      = 16;  // cycles per bit: DIV=2 times OS=8

    logic         sys_clk = 1'b0;
    logic         reset   = 1'b1;
    logic         rx      = 1'b1;
    logic         ro      = 1'b1;
    logic [0:W-1] dout;
    logic         so, frame_err, overrun, busy;

    int checks = 0, errors = 0, cyc = 0;
    int fe_cnt = 0, ov_cnt = 0;
    int so_rise_cyc = -1, stop_start_cyc = 0;
    logic so_prev = 1'b0;
    logic busy_seen = 1'b0;
    logic t6_done = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] exp_q[$];

    uart_rx_core #(
        .SYS_CLK_FREQ(CLK_FREQ),
        .BAUD_RATE   (BAUD),
        .FRAME_WIDTH (W),
        .OVERSAMPLE  (OS)
    ) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .rx       (rx),
        .dout     (dout),
        .so       (so),
        .ro       (ro),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (so && ro) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_so dout=%h with no byte expected", dout);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dout !== mon_exp) begin
                    errors++;
                    $display("FAIL rx_byte got %h expected %h", dout, mon_exp);
                end
            end
        end
        if (frame_err && overrun) begin
            checks++;
            errors++;
            $display("FAIL err_exclusive frame_err=1 overrun=1 expected not both");
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (busy) busy_seen = 1'b1;
        if (so && !so_prev) so_rise_cyc = cyc;
        so_prev = so;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic push);
        if (push) exp_q.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        stop_start_cyc = cyc;
        drive_bit(stop_v);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    int fe0, ov0, delta;
    logic [7:0] partial;

    initial begin
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset_so", so, 1'b0);
        check("reset_dout", dout, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_errs", {frame_err, overrun}, 2'b00);
        @(posedge sys_clk);
        #1 reset = 1'b0;
        idle_bits(2);

        // 1: single frame, latency of so relative to stop-bit start
        send_frame(8'hA5, 1'b1, 1'b1);
        idle_bits(2);
        check("t1_delivered", exp_q.size(), 0);
        delta = so_rise_cyc - stop_start_cyc;
        check("t1_latency_ok", (delta >= BIT / 2) && (delta <= BIT / 2 + 10), 1'b1);
        check("t1_frame_err", fe_cnt, 0);
        check("t1_overrun", ov_cnt, 0);

        // 2: three-tick low glitch is rejected
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (6) @(posedge sys_clk);
        #1 rx = 1'b1;
        repeat (BIT) @(posedge sys_clk);
        @(negedge sys_clk);
        check("t2_busy_seen", busy_seen, 1'b1);
        check("t2_busy_back", busy, 1'b0);
        check("t2_no_so", so, 1'b0);
        @(posedge sys_clk);
        #1;
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_bits(2);
        check("t2_delivered", exp_q.size(), 0);

        // 3: stop bit 0 drops the frame
        fe0 = fe_cnt;
        send_frame(8'h00, 1'b0, 1'b0);
        idle_bits(2);
        check("t3_frame_err", fe_cnt - fe0, 1);
        check("t3_no_so", so, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle_bits(2);
        check("t3_delivered", exp_q.size(), 0);
        check("t3_frame_err_after", fe_cnt - fe0, 1);

        // 4: overrun with ro held low
        ro  = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0);
        idle_bits(2);
        @(negedge sys_clk);
        check("t4_so_held", so, 1'b1);
        check("t4_dout_held", dout, 8'h11);
        check("t4_overrun", ov_cnt - ov0, 1);
        @(posedge sys_clk);
        #1 ro = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("t4_so_drop", so, 1'b0);
        check("t4_delivered", exp_q.size(), 0);
        @(posedge sys_clk);
        #1;

        // 5: reset in the middle of data bit 4
        partial = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rx = partial[4];
        repeat (BIT / 2) @(posedge sys_clk);
        #1;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 reset = 1'b0;
        @(negedge sys_clk);
        check("t5_so", so, 1'b0);
        check("t5_dout", dout, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_errs", {frame_err, overrun}, 2'b00);
        @(posedge sys_clk);
        #1;
        idle_bits(12);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle_bits(2);
        check("t5_delivered", exp_q.size(), 0);

        // 6: bytes 1..255 back-to-back with ro toggling
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        fork
            begin
                for (int b = 1; b < 256; b++) begin
                    partial = b[7:0];
                    send_frame(partial, 1'b1, 1'b1);
                end
                t6_done = 1'b1;
            end
            begin
                while (!t6_done) begin
                    @(posedge sys_clk);
                    #2 ro = 1'($urandom_range(0, 1));
                end
            end
        join
        ro = 1'b1;
        idle_bits(3);
        check("t6_all_delivered", exp_q.size(), 0);
        check("t6_frame_err", fe_cnt - fe0, 0);
        check("t6_overrun", ov_cnt - ov0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
